// File: rtl/btn_if.sv
// Button bundle between raw switch inputs and the conditioner.
// Master drives raw levels/enables, slave returns conditioned events.
interface btn_if #(
  parameter int NUM_BTN = 4
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] repeat_en;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  modport master (
    output btn_raw,
    output repeat_en,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    input  repeat_en,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/btn_conditioner.sv
// Per-button sync, debounce, edge pulses and hold-to-repeat.
// All outputs are registered; channels are fully independent.
module btn_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 512,
  parameter int REPEAT_DELAY    = 5_000_000,
  parameter int REPEAT_RATE     = 2_000_000,
  parameter int CNT_W           = 24
) (
  input  logic   clk,
  input  logic   reset,
  btn_if.slave   bus
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] RC_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RPT
  } state_t;

  logic [NUM_BTN-1:0] s1;
  logic [NUM_BTN-1:0] s2;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] level_n;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] press_n;
  logic [NUM_BTN-1:0] rel;
  logic [NUM_BTN-1:0] rel_n;
  logic [NUM_BTN-1:0] chg;
  logic [DB_W-1:0]    dbc   [NUM_BTN];
  logic [DB_W-1:0]    dbc_n [NUM_BTN];
  logic [CNT_W-1:0]   rc    [NUM_BTN];
  logic [CNT_W-1:0]   rc_n  [NUM_BTN];
  state_t             st    [NUM_BTN];
  state_t             st_n  [NUM_BTN];

  // State register: sync flops, debounce, repeat FSM and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      level <= '0;
      press <= '0;
      rel   <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        dbc[i] <= '0;
        rc[i]  <= '0;
        st[i]  <= IDLE;
      end
    end else begin
      s1    <= bus.btn_raw;
      s2    <= s1;
      level <= level_n;
      press <= press_n;
      rel   <= rel_n;
      for (int i = 0; i < NUM_BTN; i++) begin
        dbc[i] <= dbc_n[i];
        rc[i]  <= rc_n[i];
        st[i]  <= st_n[i];
      end
    end
  end

  // Next-state: debounce accept, then repeat FSM; release wins.
  always_comb begin
    level_n = level;
    press_n = '0;
    rel_n   = '0;
    chg     = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      dbc_n[i] = '0;
      rc_n[i]  = rc[i];
      st_n[i]  = st[i];
      if (s2[i] != level[i]) begin
        if (dbc[i] == DB_LAST) begin
          chg[i]     = 1'b1;
          level_n[i] = s2[i];
        end else begin
          dbc_n[i] = dbc[i] + DB_W'(1);
        end
      end
      unique case (st[i])
        IDLE: begin
          if (chg[i] && s2[i]) begin
            st_n[i]    = HOLD;
            rc_n[i]    = '0;
            press_n[i] = 1'b1;
          end
        end
        HOLD, RPT: begin
          if (chg[i] && !s2[i]) begin
            st_n[i]  = IDLE;
            rc_n[i]  = '0;
            rel_n[i] = 1'b1;
          end else if (!bus.repeat_en[i]) begin
            st_n[i] = HOLD;
            rc_n[i] = '0;
          end else if (st[i] == HOLD && rc[i] == DLY_LAST) begin
            st_n[i]    = RPT;
            rc_n[i]    = '0;
            press_n[i] = 1'b1;
          end else if (st[i] == RPT && rc[i] == RATE_LAST) begin
            rc_n[i]    = '0;
            press_n[i] = 1'b1;
          end else if (rc[i] != RC_MAX) begin
            rc_n[i] = rc[i] + CNT_W'(1);
          end
        end
        default: begin
          st_n[i] = IDLE;
          rc_n[i] = '0;
        end
      endcase
    end
  end

  assign bus.btn_level   = level;
  assign bus.btn_press   = press;
  assign bus.btn_release = rel;
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed per-cycle check of btn_conditioner with short timings.
// Stimulus and expected pulses come from hand-built tables.
module tb_btn_conditioner;
  localparam int NB = 4;
  localparam int LAST_CYC = 400;

  typedef struct {
    int         cyc;
    logic [3:0] raw;
    logic [3:0] en;
    logic       rst;
  } stim_t;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] set;
    logic [3:0] clr;
  } exp_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  btn_if #(.NUM_BTN(NB)) bus ();

  btn_conditioner #(
    .NUM_BTN(NB),
    .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY(20),
    .REPEAT_RATE(5),
    .CNT_W(24)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int c,
                       input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b want %b", name, c, act, exp);
    end
  endtask

  stim_t      stim [$];
  exp_t       ex   [$];
  logic [3:0] e_lvl;
  logic [3:0] e_prs;
  logic [3:0] e_rel;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    // Stimulus: value applied so it is sampled at edge cyc.
    stim.push_back('{0,   4'b0000, 4'b0000, 1'b1});
    stim.push_back('{3,   4'b0000, 4'b1000, 1'b0});
    stim.push_back('{10,  4'b0001, 4'b1000, 1'b0});
    stim.push_back('{25,  4'b0000, 4'b1000, 1'b0});
    stim.push_back('{30,  4'b0100, 4'b1000, 1'b0});
    stim.push_back('{40,  4'b0110, 4'b1000, 1'b0});
    stim.push_back('{46,  4'b0100, 4'b1000, 1'b0});
    stim.push_back('{50,  4'b0000, 4'b1000, 1'b0});
    stim.push_back('{55,  4'b0010, 4'b1000, 1'b0});
    stim.push_back('{70,  4'b0000, 4'b1000, 1'b0});
    stim.push_back('{85,  4'b1000, 4'b1000, 1'b0});
    stim.push_back('{154, 4'b0000, 4'b1000, 1'b0});
    stim.push_back('{170, 4'b0000, 4'b0000, 1'b0});
    stim.push_back('{175, 4'b1000, 4'b0000, 1'b0});
    stim.push_back('{235, 4'b0000, 4'b0000, 1'b0});
    stim.push_back('{250, 4'b0011, 4'b0000, 1'b0});
    stim.push_back('{270, 4'b0011, 4'b0000, 1'b1});
    stim.push_back('{273, 4'b0011, 4'b0000, 1'b0});
    stim.push_back('{290, 4'b0000, 4'b0000, 1'b0});
    stim.push_back('{315, 4'b0000, 4'b1000, 1'b0});
    stim.push_back('{320, 4'b1000, 4'b1000, 1'b0});
    stim.push_back('{352, 4'b1000, 4'b0000, 1'b0});
    stim.push_back('{360, 4'b1000, 4'b1000, 1'b0});
    stim.push_back('{385, 4'b0000, 4'b1000, 1'b0});

    // Expected outputs visible after edge cyc.
    ex.push_back('{19,  4'b0001, 4'b0000, 4'b0001, 4'b0000});
    ex.push_back('{34,  4'b0000, 4'b0001, 4'b0000, 4'b0001});
    ex.push_back('{39,  4'b0100, 4'b0000, 4'b0100, 4'b0000});
    ex.push_back('{59,  4'b0000, 4'b0100, 4'b0000, 4'b0100});
    ex.push_back('{64,  4'b0010, 4'b0000, 4'b0010, 4'b0000});
    ex.push_back('{79,  4'b0000, 4'b0010, 4'b0000, 4'b0010});
    ex.push_back('{94,  4'b1000, 4'b0000, 4'b1000, 4'b0000});
    for (int c = 114; c <= 159; c += 5)
      ex.push_back('{c, 4'b1000, 4'b0000, 4'b0000, 4'b0000});
    ex.push_back('{163, 4'b0000, 4'b1000, 4'b0000, 4'b1000});
    ex.push_back('{184, 4'b1000, 4'b0000, 4'b1000, 4'b0000});
    ex.push_back('{244, 4'b0000, 4'b1000, 4'b0000, 4'b1000});
    ex.push_back('{259, 4'b0011, 4'b0000, 4'b0011, 4'b0000});
    ex.push_back('{270, 4'b0000, 4'b0000, 4'b0000, 4'b0011});
    ex.push_back('{282, 4'b0011, 4'b0000, 4'b0011, 4'b0000});
    ex.push_back('{299, 4'b0000, 4'b0011, 4'b0000, 4'b0011});
    ex.push_back('{329, 4'b1000, 4'b0000, 4'b1000, 4'b0000});
    ex.push_back('{349, 4'b1000, 4'b0000, 4'b0000, 4'b0000});
    ex.push_back('{379, 4'b1000, 4'b0000, 4'b0000, 4'b0000});
    ex.push_back('{384, 4'b1000, 4'b0000, 4'b0000, 4'b0000});
    ex.push_back('{389, 4'b1000, 4'b0000, 4'b0000, 4'b0000});
    ex.push_back('{394, 4'b0000, 4'b1000, 4'b0000, 4'b1000});

    reset         = stim[0].rst;
    bus.btn_raw   = stim[0].raw;
    bus.repeat_en = stim[0].en;
    e_lvl         = 4'b0000;

    for (int c = 0; c <= LAST_CYC; c++) begin
      @(negedge clk);
      e_prs = 4'b0000;
      e_rel = 4'b0000;
      foreach (ex[j]) begin
        if (ex[j].cyc == c) begin
          e_prs = e_prs | ex[j].press;
          e_rel = e_rel | ex[j].rel;
          e_lvl = (e_lvl | ex[j].set) & ~ex[j].clr;
        end
      end
      check("btn_level", c, bus.btn_level, e_lvl);
      check("btn_press", c, bus.btn_press, e_prs);
      check("btn_release", c, bus.btn_release, e_rel);
      foreach (stim[j]) begin
        if (stim[j].cyc == c + 1) begin
          reset         = stim[j].rst;
          bus.btn_raw   = stim[j].raw;
          bus.repeat_en = stim[j].en;
        end
      end
    end

    // Reset with a held button: outputs clear at the first reset edge.
    bus.btn_raw   = 4'b0100;
    bus.repeat_en = 4'b0000;
    reset         = 1'b0;
    repeat (12) @(negedge clk);
    check("pre_rst_level", 0, bus.btn_level, 4'b0100);
    reset = 1'b1;
    @(negedge clk);
    check("rst_level", 0, bus.btn_level, 4'b0000);
    check("rst_release", 0, bus.btn_release, 4'b0000);
    reset = 1'b0;
    repeat (9) @(negedge clk);
    check("post_rst_wait", 0, bus.btn_press, 4'b0000);
    @(negedge clk);
    check("post_rst_press", 0, bus.btn_press, 4'b0100);
    check("post_rst_level", 0, bus.btn_level, 4'b0100);
    @(negedge clk);
    check("post_rst_once", 0, bus.btn_press, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Per-button input conditioning stage between the raw ui_in switches and the animation/speed control logic.
- Synchronises, debounces and edge-detects each button.
- Emits single-cycle press/release pulses, plus optional hold-to-repeat press pulses, so one physical press advances animation or speed by exactly one step.
- Replaces the level-style debounce counters in the top level; downstream consumers act only on pulses.

Parameters:
- NUM_BTN, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 512, consecutive stable cycles required to accept a level change (>=2).
- REPEAT_DELAY, 5_000_000, held cycles before first auto-repeat pulse (0.5 s at 10 MHz).
- REPEAT_RATE, 2_000_000, cycles between subsequent auto-repeat pulses (>=2).
- CNT_W, 24, width of the repeat counter; must hold max(REPEAT_DELAY, REPEAT_RATE).

Ports:
- clk  input  1  system clock, 10 MHz.
- reset  input  1  synchronous, active-high reset.
- btn_raw  input  NUM_BTN  asynchronous raw button levels, active-high.
- repeat_en  input  NUM_BTN  per-channel auto-repeat enable.
- btn_level  output  NUM_BTN  debounced, registered button level.
- btn_press  output  NUM_BTN  one-cycle pulse on debounced press or on auto-repeat.
- btn_release  output  NUM_BTN  one-cycle pulse on debounced release.

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk. While reset is high, all sync flops, debounce counters, repeat counters, btn_level, btn_press and btn_release are 0.
- Synchroniser: btn_raw[i] passes through 2 flops (s1, s2). Only s2 is used downstream.
- Debounce, per channel:
  - Counter dbc, width clog2(DEBOUNCE_CYCLES).
  - If s2 == btn_level: dbc <= 0.
  - Else if dbc == DEBOUNCE_CYCLES-1: btn_level <= s2 and dbc <= 0.
  - Else: dbc <= dbc+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes btn_level, and any return to the old level clears dbc.
- Latency: a clean raw transition sampled at edge k changes btn_level at edge k+DEBOUNCE_CYCLES+1 (2 sync stages plus DEBOUNCE_CYCLES stable samples).
- Edge pulses:
  - btn_press[i] is 1 for exactly one cycle, in the same cycle btn_level[i] first reads 1.
  - btn_release[i] is 1 for exactly one cycle, in the same cycle btn_level[i] first reads 0.
  - Both are registered outputs; no combinational path from any input.
- Repeat FSM, per channel. States are IDLE, HOLD and RPT.
  - IDLE: btn_level==0. On the press, go to HOLD with rc <= 0.
  - HOLD: rc increments each cycle. When rc == REPEAT_DELAY-1 and repeat_en[i]==1: pulse btn_press, set rc <= 0, go to RPT.
  - RPT: rc increments each cycle. When rc == REPEAT_RATE-1: pulse btn_press and set rc <= 0.
  - Debounced release from HOLD or RPT: go to IDLE, clear rc, emit btn_release.
  - repeat_en[i] low while in HOLD or RPT: go to HOLD with rc cleared and no pulses, so re-enabling restarts the full REPEAT_DELAY.
- Counter widths: rc saturates. It never wraps, and no pulse is generated from a wrapped count.
- Simultaneous events: channels are fully independent; any combination of btn_press/btn_release bits may be high in one cycle. Press and release on the same channel are never high in the same cycle.
- Reset mid-operation: clears everything. A button still held after reset deassertion is treated as a new press: full debounce, then one btn_press pulse.
- Output onehotness: no priority arbitration between channels is done here. The consumer resolves conflicts (e.g. inc and dec both pressed).

Test Plan:
Bench parameters for all cases: DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_RATE=5, NUM_BTN=4.
- Clean press: btn_raw[0] 0->1 at cycle 10 and held 15 cycles -> btn_level[0] rises at cycle 19; btn_press[0] high only in cycle 19; no other channel toggles.
- Glitch rejection: btn_raw[1] high for 6 cycles, then low -> btn_level[1] stays 0 and btn_press[1] never fires. Then hold high 8+ cycles -> exactly one press pulse.
- Release: after a debounced press on ch2, raw low at cycle 50 -> btn_release[2] single pulse at cycle 59; btn_level[2]=0 from cycle 59.
- Auto-repeat: repeat_en[3]=1, ch3 held 60 cycles after its press at cycle P -> btn_press[3] pulses at P, P+20, P+25, P+30, ...; none after release is debounced. With repeat_en[3]=0 -> only the pulse at P.
- Simultaneous and reset: ch0 and ch1 pressed in the same cycle -> both press bits high together. Reset asserted mid-hold for 3 cycles with raw still high -> all outputs 0 during reset, then one new press pulse 10 cycles after reset deassertion.
